conv_encoder: RTL and testbench

Rate-1/2, constraint-length-K convolutional encoder. It is the transmit-side counterpart of the Viterbi decoder and feeds the 2-bit symbols that the decoder's branch-metric and ACS stages consume. It accepts a fixed-length frame of data bits over a valid/ready stream and emits one 2-bit symbol per bit. It then appends K-1 zero tail bits so the trellis terminates in state 0, the state the decoder's traceback assumes.

---
 rtl/vit_pkg.sv | 16 +
 rtl/enc_parity.sv | 20 ++
 rtl/conv_encoder.sv | 127 ++++++++++++
 tb/tb_conv_encoder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vit_pkg.sv
// rtl/vit_pkg.sv - constants and types shared by the convolutional encoder and the Viterbi decoder
package vit_pkg;

  localparam int K = 3;
  localparam logic [K-1:0] G0_DEF = 3'b111;
  localparam logic [K-1:0] G1_DEF = 3'b101;

  typedef logic [1:0] sym_t;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } enc_state_t;

endpackage

// File: rtl/enc_parity.sv
// rtl/enc_parity.sv - combinational generator-polynomial parity for one trellis branch
module enc_parity
  import vit_pkg::*;
#(
  parameter int             K  = vit_pkg::K,
  parameter logic [K-1:0]   G0 = vit_pkg::G0_DEF,
  parameter logic [K-1:0]   G1 = vit_pkg::G1_DEF
) (
  input  logic         b,
  input  logic [K-2:0] sr,
  output sym_t         sym
);

  logic [K-1:0] w;

  // The current input sits at bit K-1, so it lines up with the MSB tap of each polynomial.
  assign w   = {b, sr};
  assign sym = {^(w & G0), ^(w & G1)};

endmodule

// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2 convolutional encoder with zero-tail frame termination
module conv_encoder
  import vit_pkg::*;
#(
  parameter int           K         = vit_pkg::K,
  parameter logic [K-1:0] G0        = vit_pkg::G0_DEF,
  parameter logic [K-1:0] G1        = vit_pkg::G1_DEF,
  parameter int           FRAME_LEN = 8,
  parameter int           CNT_W     = $clog2(FRAME_LEN + K)
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  input  logic in_bit,
  output logic in_ready,
  output logic out_valid,
  output sym_t out_sym,
  output logic out_last,
  input  logic out_ready,
  output logic busy
);

  enc_state_t       state_q, state_d;
  logic [K-2:0]     sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  sym_t             out_sym_q, out_sym_d;
  logic             out_last_q, out_last_d;

  logic             slot_free;
  logic             enc_b;
  logic [K-1:0]     shifted;
  sym_t             enc_sym;

  enc_parity #(.K(K), .G0(G0), .G1(G1)) u_parity (
    .b  (enc_b),
    .sr (sr_q),
    .sym(enc_sym)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign shifted   = {enc_b, sr_q};

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    in_ready    = 1'b0;
    enc_b       = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DATA;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      DATA: begin
        in_ready = slot_free;
        enc_b    = in_bit;
        if (in_valid && slot_free) begin
          out_valid_d = 1'b1;
          out_sym_d   = enc_sym;
          out_last_d  = 1'b0;
          sr_d        = shifted[K-1:1];
          if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
            state_d = TAIL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (slot_free) begin
          out_valid_d = 1'b1;
          out_sym_d   = enc_sym;
          sr_d        = shifted[K-1:1];
          // Final tail bit flushes the register; leave it cleared for the next frame.
          if (cnt_q == CNT_W'(K - 2)) begin
            out_last_d = 1'b1;
            state_d    = IDLE;
            cnt_d      = '0;
            sr_d       = '0;
          end else begin
            out_last_d = 1'b0;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - self-checking bench for conv_encoder against a convolution model
module tb_conv_encoder;

  localparam int           KK = vit_pkg::K;
  localparam logic [KK-1:0] GA = vit_pkg::G0_DEF;
  localparam logic [KK-1:0] GB = vit_pkg::G1_DEF;
  localparam int           FL = 4;
  localparam int           NS = FL + KK - 1;

  logic       clk, rst, start, in_valid, in_bit, in_ready;
  logic       out_valid, out_last, out_ready, busy;
  logic [1:0] out_sym;

  conv_encoder #(.K(KK), .G0(GA), .G1(GB), .FRAME_LEN(FL)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_sym  (out_sym),
    .out_last (out_last),
    .out_ready(out_ready),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sym;
    logic       last;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  exp_t       expq[$];
  logic [1:0] log_q[$];
  bit         toggle_rdy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Convolution of the zero-padded bit sequence with each generator; first symbol in the MSBs.
  function automatic logic [2*NS-1:0] model(input logic [FL-1:0] bits);
    logic [2*NS-1:0] v;
    logic            s1, s0, u;
    v = '0;
    for (int i = 0; i < NS; i++) begin
      s1 = 1'b0;
      s0 = 1'b0;
      for (int j = 0; j < KK; j++) begin
        u = (i - j >= 0 && i - j < FL) ? bits[i-j] : 1'b0;
        s1 ^= GA[KK-1-j] & u;
        s0 ^= GB[KK-1-j] & u;
      end
      v[2*(NS-1-i) +: 2] = {s1, s0};
    end
    return v;
  endfunction

  function automatic logic [63:0] pack_log();
    logic [63:0] v;
    v = '0;
    foreach (log_q[i]) v = {v[61:0], log_q[i]};
    return v;
  endfunction

  task automatic push_exp(input logic [FL-1:0] bits);
    logic [2*NS-1:0] v;
    exp_t            e;
    v = model(bits);
    for (int i = 0; i < NS; i++) begin
      e.sym  = v[2*(NS-1-i) +: 2];
      e.last = (i == NS - 1);
      expq.push_back(e);
    end
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle_rdy ? !out_ready : 1'b1;
    end
  end

  // Compare process: every mid-cycle sample of the output side.
  initial begin
    logic       pv, pr, pl;
    logic [1:0] ps;
    exp_t       e;
    pv = 0; pr = 0; pl = 0; ps = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (pv && !pr)
          chk("hold", {out_valid, out_sym, out_last}, {1'b1, ps, pl});
        if (out_valid && !out_ready)
          chk("in_ready_bp", in_ready, 0);
        if (out_valid && out_last && !(pv && !pr && pl))
          chk("busy_at_last", busy, 0);
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            chk("extra_sym", 1, 0);
          end else begin
            e = expq.pop_front();
            chk("sym", {out_sym, out_last}, {e.sym, e.last});
            log_q.push_back(out_sym);
          end
        end
      end
      pv = out_valid; pr = out_ready; ps = out_sym; pl = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [FL-1:0] bits, input bit b2b, input bit poke, input int nbits);
    int n;
    bit acc;
    if (b2b) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (busy && n < 200);
      if (busy) chk("timeout_idle", 0, 1);
    end
    push_exp(bits);
    start = 1; in_valid = 1; in_bit = bits[0];
    step();
    start = 0;
    for (int i = 0; i < nbits; i++) begin
      in_valid = 1; in_bit = bits[i];
      if (poke && i == 2) start = 1;
      n = 0;
      do begin
        @(negedge clk);
        acc = in_ready;
        n++;
        step();
        start = 0;
      end while (!acc && n < 100);
      if (!acc) chk("timeout_accept", 0, 1);
    end
    in_valid = 0;
    if (poke && nbits == FL) begin
      start = 1;
      step();
      start = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || expq.size() != 0 || out_valid) && n < 300);
    if (busy || expq.size() != 0) chk("timeout_drain", 0, 1);
    step();
  endtask

  task automatic run_frame(input string name, input logic [FL-1:0] bits, input bit poke,
                           input logic [63:0] lit);
    log_q.delete();
    send_frame(bits, 0, poke, FL);
    drain();
    chk({name, "_count"}, log_q.size(), NS);
    chk({name, "_seq"}, pack_log(), lit);
  endtask

  initial begin
    rst = 1; start = 0; in_valid = 0; in_bit = 0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_state", {out_valid, out_sym, out_last, busy, in_ready}, 6'b0);
    rst = 0;
    step();

    chk("model_1011", model(4'b1101), 12'hE17);
    chk("model_ones", model(4'b1111), 12'hDA7);
    chk("model_zero", model(4'b0000), 12'h000);

    run_frame("basic", 4'b1101, 0, 64'hE17);

    toggle_rdy = 1;
    run_frame("backpressure", 4'b1101, 0, 64'hE17);
    toggle_rdy = 0;

    log_q.delete();
    send_frame(4'b1101, 0, 0, 2);
    rst = 1;
    step();
    expq.delete();
    @(negedge clk);
    chk("rst_mid_frame", {out_valid, busy, out_sym, out_last}, 5'b0);
    rst = 0;
    step();
    run_frame("after_rst", 4'b1101, 0, 64'hE17);

    run_frame("start_ignored", 4'b1101, 1, 64'hE17);
    toggle_rdy = 1;
    run_frame("start_ignored_bp", 4'b1101, 1, 64'hE17);
    toggle_rdy = 0;

    run_frame("zeros", 4'b0000, 0, 64'h000);
    run_frame("ones", 4'b1111, 0, 64'hDA7);

    log_q.delete();
    send_frame(4'b1101, 0, 0, FL);
    send_frame(4'b1111, 1, 0, FL);
    drain();
    chk("b2b_count", log_q.size(), 2 * NS);
    chk("b2b_seq", pack_log(), 64'hE17DA7);

    toggle_rdy = 1;
    log_q.delete();
    send_frame(4'b1111, 0, 0, FL);
    send_frame(4'b1101, 1, 0, FL);
    drain();
    toggle_rdy = 0;
    chk("b2b_bp_count", log_q.size(), 2 * NS);
    chk("b2b_bp_seq", pack_log(), 64'hDA7E17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
